// File: rtl/stream_error_monitor.sv
// Aligns a reference stream to DUT outputs and reports per-channel wrap/absolute errors and mismatch statistics.
// Optional first-fail capture registers are built when STREAM_ERRMON_FIRST_FAIL_EN is defined.
module stream_error_monitor #(
    parameter int WIDTH    = 13,
    parameter int CHANNELS = 2,
    parameter int LATENCY  = 1,
    parameter int TOL      = 0,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      ref_valid,
    input  logic [CHANNELS*WIDTH-1:0] ref_data,
    input  logic [CHANNELS*WIDTH-1:0] dut_data,
    output logic                      err_valid,
    output logic [CHANNELS*WIDTH-1:0] err_out,
    output logic [CHANNELS*WIDTH-1:0] abs_err,
    output logic [CHANNELS*WIDTH-1:0] max_abs_err,
    output logic [CHANNELS*CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0]          sample_cnt,
    output logic                      fail,
    output logic [CNT_W-1:0]          first_fail_idx,
    output logic [CHANNELS-1:0]       first_fail_ch
);
    localparam int               DW      = CHANNELS * WIDTH;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [WIDTH-1:0] TOL_V   = WIDTH'(TOL);

    logic          al_valid;
    logic [DW-1:0] al_data;

    generate
        if (LATENCY == 0) begin : g_wire
            assign al_valid = ref_valid;
            assign al_data  = ref_data;
        end else begin : g_pipe
            logic [LATENCY-1:0] vld_q;
            logic [DW-1:0]      dat_q [LATENCY];

            always_ff @(posedge clk) begin
                if (reset) begin
                    vld_q <= '0;
                end else begin
                    vld_q[0] <= ref_valid;
                    for (int i = 1; i < LATENCY; i++) vld_q[i] <= vld_q[i-1];
                end
            end

            // NOTE: data stages carry no reset; only the valid bits decide whether an entry is used.
            always_ff @(posedge clk) begin
                dat_q[0] <= ref_data;
                for (int i = 1; i < LATENCY; i++) dat_q[i] <= dat_q[i-1];
            end

            assign al_valid = vld_q[LATENCY-1];
            assign al_data  = dat_q[LATENCY-1];
        end
    endgenerate

    logic [DW-1:0]       err_d;
    logic [DW-1:0]       abs_d;
    logic [CHANNELS-1:0] mis;

    // The borrow bit of the widened difference selects the subtraction order for |d|.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] u;
        logic [WIDTH:0]   diff;
        assign r    = al_data[k*WIDTH +: WIDTH];
        assign u    = dut_data[k*WIDTH +: WIDTH];
        assign diff = {1'b0, r} - {1'b0, u};
        assign err_d[k*WIDTH +: WIDTH] = diff[WIDTH-1:0];
        assign abs_d[k*WIDTH +: WIDTH] = diff[WIDTH] ? (u - r) : (r - u);
        assign mis[k] = abs_d[k*WIDTH +: WIDTH] > TOL_V;
    end

    logic                      err_valid_q;
    logic [DW-1:0]             err_q, abs_q;
    logic [DW-1:0]             max_q, max_d;
    logic [CHANNELS*CNT_W-1:0] mcnt_q, mcnt_d;
    logic [CNT_W-1:0]          smp_q, smp_d;
    logic                      fail_q, fail_d;

    always_comb begin
        // NOTE: every next-state value defaults to its register first, so no path can infer a latch.
        smp_d  = smp_q;
        max_d  = max_q;
        mcnt_d = mcnt_q;
        fail_d = fail_q;
        if (clear) begin
            smp_d  = '0;
            max_d  = '0;
            mcnt_d = '0;
            fail_d = 1'b0;
        end else if (al_valid) begin
            if (smp_q != CNT_MAX) smp_d = smp_q + CNT_ONE;
            for (int k = 0; k < CHANNELS; k++) begin
                if (abs_d[k*WIDTH +: WIDTH] > max_q[k*WIDTH +: WIDTH])
                    max_d[k*WIDTH +: WIDTH] = abs_d[k*WIDTH +: WIDTH];
                if (mis[k] && (mcnt_q[k*CNT_W +: CNT_W] != CNT_MAX))
                    mcnt_d[k*CNT_W +: CNT_W] = mcnt_q[k*CNT_W +: CNT_W] + CNT_ONE;
            end
            if (|mis) fail_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_valid_q <= 1'b0;
            err_q       <= '0;
            abs_q       <= '0;
            max_q       <= '0;
            mcnt_q      <= '0;
            smp_q       <= '0;
            fail_q      <= 1'b0;
        end else begin
            err_valid_q <= al_valid;
            if (al_valid) begin
                err_q <= err_d;
                abs_q <= abs_d;
            end
            max_q  <= max_d;
            mcnt_q <= mcnt_d;
            smp_q  <= smp_d;
            fail_q <= fail_d;
        end
    end

`ifdef STREAM_ERRMON_FIRST_FAIL_EN
    logic [CNT_W-1:0]    ff_idx_q, ff_idx_d;
    logic [CHANNELS-1:0] ff_ch_q, ff_ch_d;

    // Captured against the post-increment count, i.e. the sample_cnt shown alongside the first fail.
    always_comb begin
        ff_idx_d = ff_idx_q;
        ff_ch_d  = ff_ch_q;
        if (clear) begin
            ff_idx_d = '0;
            ff_ch_d  = '0;
        end else if (fail_d && !fail_q) begin
            ff_idx_d = smp_d;
            ff_ch_d  = mis;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ff_idx_q <= '0;
            ff_ch_q  <= '0;
        end else begin
            ff_idx_q <= ff_idx_d;
            ff_ch_q  <= ff_ch_d;
        end
    end

    assign first_fail_idx = ff_idx_q;
    assign first_fail_ch  = ff_ch_q;
`else
    assign first_fail_idx = '0;
    assign first_fail_ch  = '0;
`endif

    assign err_valid    = err_valid_q;
    assign err_out      = err_q;
    assign abs_err      = abs_q;
    assign max_abs_err  = max_q;
    assign mismatch_cnt = mcnt_q;
    assign sample_cnt   = smp_q;
    assign fail         = fail_q;

endmodule

// File: tb/tb_stream_error_monitor.sv
// Directed bench: instance A uses default parameters, instance B uses LATENCY=4, TOL=2, CNT_W=4.
`timescale 1ns/1ps
module tb_stream_error_monitor;
    localparam int W     = 13;
    localparam int DW    = 2 * W;
    localparam int LAT_B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          a_rst, a_clr, a_vld;
    logic [DW-1:0] a_ref, a_dut;
    logic          a_ev, a_fail;
    logic [DW-1:0] a_err, a_abs, a_max;
    logic [31:0]   a_mc;
    logic [15:0]   a_sc, a_ffi;
    logic [1:0]    a_ffc;

    logic          b_rst, b_clr, b_vld;
    logic [DW-1:0] b_ref, b_dut;
    logic          b_ev, b_fail;
    logic [DW-1:0] b_err, b_abs, b_max;
    logic [7:0]    b_mc;
    logic [3:0]    b_sc, b_ffi;
    logic [1:0]    b_ffc;

    stream_error_monitor u_dut_a (
        .clk(clk), .reset(a_rst), .clear(a_clr), .ref_valid(a_vld),
        .ref_data(a_ref), .dut_data(a_dut), .err_valid(a_ev), .err_out(a_err),
        .abs_err(a_abs), .max_abs_err(a_max), .mismatch_cnt(a_mc), .sample_cnt(a_sc),
        .fail(a_fail), .first_fail_idx(a_ffi), .first_fail_ch(a_ffc)
    );

    stream_error_monitor #(.LATENCY(LAT_B), .TOL(2), .CNT_W(4)) u_dut_b (
        .clk(clk), .reset(b_rst), .clear(b_clr), .ref_valid(b_vld),
        .ref_data(b_ref), .dut_data(b_dut), .err_valid(b_ev), .err_out(b_err),
        .abs_err(b_abs), .max_abs_err(b_max), .mismatch_cnt(b_mc), .sample_cnt(b_sc),
        .fail(b_fail), .first_fail_idx(b_ffi), .first_fail_ch(b_ffc)
    );

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] qr[$];
    logic [DW-1:0] qd[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        return {W'(i * 97 + 5), W'(i * 41 + 1)};
    endfunction

    // Reference j is driven in slot j, its DUT value LATENCY slots later; the last result is visible on return.
    task automatic run_a(input bit clr_last);
        int n = qr.size();
        for (int i = 0; i < n + 1; i++) begin
            a_vld = (i < n);
            if (i < n) a_ref = qr[i];
            if (i >= 1) a_dut = qd[i-1];
            a_clr = clr_last && (i == n);
            cyc();
        end
        a_vld = 1'b0;
        a_clr = 1'b0;
        qr.delete();
        qd.delete();
    endtask

    task automatic run_b(input bit clr_last);
        int n = qr.size();
        for (int i = 0; i < n + LAT_B; i++) begin
            b_vld = (i < n);
            if (i < n) b_ref = qr[i];
            if (i >= LAT_B) b_dut = qd[i-LAT_B];
            b_clr = clr_last && (i == n + LAT_B - 1);
            cyc();
        end
        b_vld = 1'b0;
        b_clr = 1'b0;
        qr.delete();
        qd.delete();
    endtask

    initial begin
        int seen;
        a_rst = 1'b1; a_clr = 1'b0; a_vld = 1'b0; a_ref = '0; a_dut = '0;
        b_rst = 1'b1; b_clr = 1'b0; b_vld = 1'b0; b_ref = '0; b_dut = '0;
        repeat (3) cyc();
        chk("rst_a_ev",   a_ev,   0);
        chk("rst_a_err",  a_err,  0);
        chk("rst_a_sc",   a_sc,   0);
        chk("rst_a_fail", a_fail, 0);
        chk("rst_b_mc",   b_mc,   0);
        chk("rst_b_max",  b_max,  0);
        a_rst = 1'b0;
        b_rst = 1'b0;

        // 100 matched samples
        for (int i = 0; i < 100; i++) begin
            qr.push_back(pat(i));
            qd.push_back(pat(i));
        end
        run_a(1'b0);
        chk("match_ev",   a_ev,   1);
        chk("match_err",  a_err,  0);
        chk("match_abs",  a_abs,  0);
        chk("match_mc",   a_mc,   0);
        chk("match_sc",   a_sc,   100);
        chk("match_fail", a_fail, 0);
        chk("match_max",  a_max,  0);
        cyc();
        chk("match_gap_ev", a_ev, 0);
        chk("match_sc_hold", a_sc, 100);

        a_clr = 1'b1; cyc(); a_clr = 1'b0;
        chk("clr_a_sc", a_sc, 0);

        // single error on the 37th sample, channel 1
        for (int i = 0; i < 37; i++) begin
            qr.push_back(pat(i + 200));
            qd.push_back(pat(i + 200));
        end
        qr[36] = {13'h0100, 13'h0555};
        qd[36] = {13'h00F0, 13'h0555};
        run_a(1'b0);
        chk("single_err",  a_err,  {13'h0010, 13'h0000});
        chk("single_abs",  a_abs,  {13'd16, 13'd0});
        chk("single_mc",   a_mc,   {16'd1, 16'd0});
        chk("single_fail", a_fail, 1);
        chk("single_sc",   a_sc,   37);
        chk("single_max",  a_max,  {13'd16, 13'd0});
`ifdef STREAM_ERRMON_FIRST_FAIL_EN
        chk("single_ffi", a_ffi, 37);
        chk("single_ffc", a_ffc, 2'b10);
`else
        chk("single_ffi", a_ffi, 0);
        chk("single_ffc", a_ffc, 0);
`endif

        a_clr = 1'b1; cyc(); a_clr = 1'b0;
        chk("clr_a_fail", a_fail, 0);

        // wrap-around on channel 0, then a large negative difference on channel 1
        qr.push_back({13'h0AAA, 13'h0000}); qd.push_back({13'h0AAA, 13'h0001});
        run_a(1'b0);
        chk("wrap_err", a_err, {13'h0000, 13'h1FFF});
        chk("wrap_abs", a_abs, {13'h0000, 13'h0001});
        chk("wrap_max", a_max, {13'h0000, 13'h0001});
        qr.push_back({13'h0005, 13'h0003}); qd.push_back({13'h1FFE, 13'h0003});
        run_a(1'b0);
        chk("neg_err", a_err, {13'h0007, 13'h0000});
        chk("neg_abs", a_abs, {13'h1FF9, 13'h0000});
        chk("neg_max", a_max, {13'h1FF9, 13'h0001});
        chk("neg_mc",  a_mc,  {16'd1, 16'd1});
`ifdef STREAM_ERRMON_FIRST_FAIL_EN
        chk("wrap_ffi", a_ffi, 1);
        chk("wrap_ffc", a_ffc, 2'b01);
`endif

        // clear coincident with a compare: result still emitted, not counted
        qr.push_back({13'h0000, 13'h0010}); qd.push_back({13'h0000, 13'h0000});
        run_a(1'b1);
        chk("clrcmp_a_ev",   a_ev,   1);
        chk("clrcmp_a_err",  a_err,  {13'h0000, 13'h0010});
        chk("clrcmp_a_sc",   a_sc,   0);
        chk("clrcmp_a_mc",   a_mc,   0);
        chk("clrcmp_a_fail", a_fail, 0);
        chk("clrcmp_a_max",  a_max,  0);

        // tolerance: abs 2 then 3 with TOL=2
        qr.push_back({13'd0, 13'd10}); qd.push_back({13'd0, 13'd8});
        qr.push_back({13'd0, 13'd10}); qd.push_back({13'd0, 13'd13});
        run_b(1'b0);
        chk("tol_err",  b_err,  {13'd0, 13'h1FFD});
        chk("tol_abs",  b_abs,  {13'd0, 13'd3});
        chk("tol_mc",   b_mc,   {4'd0, 4'd1});
        chk("tol_sc",   b_sc,   2);
        chk("tol_fail", b_fail, 1);
`ifdef STREAM_ERRMON_FIRST_FAIL_EN
        chk("tol_ffi", b_ffi, 2);
        chk("tol_ffc", b_ffc, 2'b01);
`endif

        // saturation at 15 after 20 further mismatches
        for (int i = 0; i < 20; i++) begin
            qr.push_back({13'd0, 13'd20});
            qd.push_back({13'd0, 13'd15});
        end
        run_b(1'b0);
        chk("sat_mc",  b_mc,  {4'd0, 4'hF});
        chk("sat_sc",  b_sc,  4'hF);
        chk("sat_max", b_max, {13'd0, 13'd5});

        qr.push_back({13'd7, 13'd20}); qd.push_back({13'd0, 13'd15});
        run_b(1'b1);
        chk("clrcmp_b_ev",   b_ev,   1);
        chk("clrcmp_b_abs",  b_abs,  {13'd7, 13'd5});
        chk("clrcmp_b_sc",   b_sc,   0);
        chk("clrcmp_b_mc",   b_mc,   0);
        chk("clrcmp_b_max",  b_max,  0);
        chk("clrcmp_b_fail", b_fail, 0);

        // reset mid-stream, two cycles after a reference is accepted
        qr.push_back({13'd0, 13'd9}); qd.push_back({13'd0, 13'd0});
        run_b(1'b0);
        chk("pre_rst_fail", b_fail, 1);
        b_ref = {13'h0001, 13'h0001}; b_dut = '0; b_vld = 1'b1; cyc();
        b_vld = 1'b0; cyc();
        b_rst = 1'b1; cyc();
        b_rst = 1'b0;
        chk("midrst_ev",   b_ev,   0);
        chk("midrst_err",  b_err,  0);
        chk("midrst_abs",  b_abs,  0);
        chk("midrst_max",  b_max,  0);
        chk("midrst_mc",   b_mc,   0);
        chk("midrst_sc",   b_sc,   0);
        chk("midrst_fail", b_fail, 0);
        chk("midrst_ffi",  b_ffi,  0);
        chk("midrst_ffc",  b_ffc,  0);
        seen = 0;
        repeat (8) begin
            cyc();
            if (b_ev) seen++;
        end
        chk("midrst_no_ev", seen, 0);
        chk("midrst_sc_after", b_sc, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
